// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampled UART receiver (5-9 data bits, 1/2 stop bits, break detect, FWFT FIFO).
// Define UART_RX_PARITY_EN to build runtime even/odd parity support.
module uart_rx_ext #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx_en,
    input  logic                            rx_serial,
    input  logic [1:0]                      parity_mode,
    input  logic                            stop_bits,
    input  logic                            rd_en,
    input  logic                            err_clr,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_perr,
    output logic                            rx_ferr,
    output logic                            rx_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            rx_busy,
    output logic                            overrun,
    output logic                            break_det
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW    = $clog2(OVERSAMPLE);
    localparam int M     = OVERSAMPLE / 2;
    localparam int BW    = $clog2(DATA_BITS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int EW    = DATA_BITS + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, sync3_q;
    logic                 rx_s, fall, start_go;
    logic [DIV_W-1:0]     div_cnt_q;
    logic [SW-1:0]        samp_cnt_q;
    logic [1:0]           vote_q;
    logic                 tick, decide, bit_val;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 two_stop_q, two_stop_d;
    logic                 push, push_ferr, break_set, brk_zero;
    logic [EW-1:0]        push_word;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rx_s     = sync2_q;
    assign fall     = sync3_q & ~sync2_q;
    assign start_go = (state_q == S_IDLE) && rx_en && fall;

    // Tick k of a bit (1-based) arrives while samp_cnt_q == k-1; samples at ticks M-1, M, M+1.
    assign tick    = (div_cnt_q == DIV_W'(DIV - 1));
    assign decide  = tick && (samp_cnt_q == SW'(M));
    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            samp_cnt_q <= '0;
            vote_q     <= 2'b11;
        end else if (start_go) begin
            div_cnt_q  <= '0;
            samp_cnt_q <= '0;
        end else if (tick) begin
            div_cnt_q  <= '0;
            samp_cnt_q <= (samp_cnt_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt_q + 1'b1;
            if (samp_cnt_q == SW'(M - 2)) vote_q[0] <= rx_s;
            if (samp_cnt_q == SW'(M - 1)) vote_q[1] <= rx_s;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_en_d, par_odd_q, par_odd_d, par_bit_q, par_bit_d, perr_q, perr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
        end
    end

    assign brk_zero  = (shift_q == '0) && !(par_en_q && par_bit_q);
    assign push_word = {push_ferr, perr_q, shift_q};
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
    assign brk_zero  = (shift_q == '0);
    assign push_word = {push_ferr, 1'b0, shift_q};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            stop_idx_q <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            stop_idx_q <= stop_idx_d;
            two_stop_q <= two_stop_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_idx_d = stop_idx_q;
        two_stop_d = two_stop_q;
`ifdef UART_RX_PARITY_EN
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
`endif
        push       = 1'b0;
        push_ferr  = 1'b0;
        break_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    state_d    = S_START;
                    bit_cnt_d  = '0;
                    stop_idx_d = 1'b0;
                    two_stop_d = stop_bits;
`ifdef UART_RX_PARITY_EN
                    par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_odd_d  = (parity_mode == 2'b10);
                    par_bit_d  = 1'b0;
                    perr_d     = 1'b0;
`endif
                end
            end
            S_START: begin
                if (decide) state_d = bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (decide) begin
                    par_bit_d = bit_val;
                    perr_d    = (^shift_q) ^ bit_val ^ par_odd_q;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (decide) begin
                    if (!bit_val) begin
                        if (!stop_idx_q && brk_zero) begin
                            break_set = 1'b1;
                            state_d   = S_BRK_WAIT;
                        end else begin
                            push      = 1'b1;
                            push_ferr = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end else if (!stop_idx_q && two_stop_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_BRK_WAIT: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Dropping the enable abandons the frame without touching FIFO or flags.
        if (!rx_en && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            push      = 1'b0;
            push_ferr = 1'b0;
            break_set = 1'b0;
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, do_push, do_pop, overrun_set;
    logic          overrun_q, break_q;
    logic [EW-1:0] head;

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign do_pop      = rd_en & ~empty;
    assign do_push     = push & (~full | do_pop);
    assign overrun_set = push & full & ~do_pop;

    // NOTE: storage has no reset; the head is masked while empty so stale entries never leak out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overrun_q <= overrun_set | (overrun_q & ~err_clr);
            break_q   <= break_set | (break_q & ~err_clr);
        end
    end

    assign head       = empty ? '0 : mem_q[rd_ptr_q];
    assign rx_data    = head[DATA_BITS-1:0];
    assign rx_ferr    = head[EW-1];
    assign rx_valid   = ~empty;
    assign fifo_count = count_q;
    assign rx_busy    = (state_q != S_IDLE);
    assign overrun    = overrun_q;
    assign break_det  = break_q;
`ifdef UART_RX_PARITY_EN
    assign rx_perr = head[DATA_BITS];
`else
    logic unused_head_perr;
    assign unused_head_perr = head[DATA_BITS];
    assign rx_perr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: directed test-plan steps followed by randomized frames,
// compared against a frame-level reference model (queue of expected words plus sticky flags).
module tb_uart_rx_ext;
    localparam int CLK_FREQ   = 32;
    localparam int BAUD_RATE  = 1;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT        = OVERSAMPLE * (CLK_FREQ / (BAUD_RATE * OVERSAMPLE));
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst, rx_en, rx_serial, stop_bits, rd_en, err_clr;
    logic [1:0]           parity_mode;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr, rx_ferr, rx_valid, rx_busy, overrun, break_det;
    logic [2:0]           fifo_count;

    uart_rx_ext #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_serial(rx_serial),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .rd_en(rd_en), .err_clr(err_clr),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
        .fifo_count(fifo_count), .rx_busy(rx_busy), .overrun(overrun), .break_det(break_det)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected FIFO contents as {ferr, perr, data} plus sticky flags.
    logic [9:0] exp_q[$];
    bit         exp_ovr = 1'b0;
    bit         exp_brk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fifo(input string tag);
        check($sformatf("%s.count", tag), 32'(fifo_count), exp_q.size());
        check($sformatf("%s.valid", tag), 32'(rx_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check($sformatf("%s.data", tag), 32'(rx_data), 32'(exp_q[0][7:0]));
            check($sformatf("%s.perr", tag), 32'(rx_perr), 32'(exp_q[0][8]));
            check($sformatf("%s.ferr", tag), 32'(rx_ferr), 32'(exp_q[0][9]));
        end else begin
            check($sformatf("%s.data0", tag), 32'(rx_data), 32'd0);
        end
    endtask

    task automatic check_flags(input string tag);
        check($sformatf("%s.overrun", tag), 32'(overrun), 32'(exp_ovr));
        check($sformatf("%s.break", tag), 32'(break_det), 32'(exp_brk));
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        repeat (BIT) @(negedge clk);
    endtask

    // Sends one frame using the current parity_mode/stop_bits and updates the model.
    task automatic rx_frame(input logic [7:0] data, input logic pbit, input logic s1, input logic s2);
        bit   has_par, two, perr, ferr;
        has_par = PAR_BUILT && (parity_mode == 2'b01 || parity_mode == 2'b10);
        two     = stop_bits;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(s1);
        if (two) drive_bit(s2);
        rx_serial = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        if (data == 8'h00 && !(has_par && pbit) && !s1) begin
            exp_brk = 1'b1;
        end else begin
            perr = has_par && (((^data) ^ pbit) != (parity_mode == 2'b10));
            ferr = !s1 || (two && !s2);
            if (exp_q.size() == FIFO_DEPTH) exp_ovr = 1'b1;
            else exp_q.push_back({ferr, perr, data});
        end
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_brk = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] abort_byte;
        logic       pb, s1, s2;

        rst = 1'b1; rx_en = 1'b0; rx_serial = 1'b1; parity_mode = 2'b00;
        stop_bits = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.busy", 32'(rx_busy), 32'd0);
        check("reset.perr", 32'(rx_perr), 32'd0);
        check("reset.ferr", 32'(rx_ferr), 32'd0);
        check_fifo("reset");
        check_flags("reset");
        rx_en = 1'b1;

        // Basic 8N1 receive, FIFO ordering and pop.
        rx_frame(8'h55, 1'b0, 1'b1, 1'b1);
        rx_frame(8'hA3, 1'b0, 1'b1, 1'b1);
        check_fifo("basic");
        pop();
        check_fifo("basic_pop1");
        pop();
        pop();
        check_fifo("empty_pop");

`ifdef UART_RX_PARITY_EN
        parity_mode = 2'b01;
        rx_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        check_fifo("even_bad");
        parity_mode = 2'b10;
        rx_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        pop();
        check_fifo("odd_good");
        pop();
`else
        parity_mode = 2'b01;
        rx_frame(8'hA3, 1'b0, 1'b1, 1'b1);
        check_fifo("parity_ignored");
        pop();
`endif
        parity_mode = 2'b00;

        // Framing error on second stop bit.
        stop_bits = 1'b1;
        rx_frame(8'h12, 1'b0, 1'b1, 1'b0);
        check_fifo("framing");
        pop();
        stop_bits = 1'b0;

        // Break: line low for 20 bit times, then idle.
        rx_serial = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        rx_serial = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        exp_brk = 1'b1;
        check_flags("break");
        check_fifo("break");
        rx_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        check_fifo("after_break");
        clear_errs();
        check_flags("break_clr");
        pop();

        // Overrun: five words into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b0, 1'b1, 1'b1);
        check_fifo("overrun_full");
        check_flags("overrun");
        for (int i = 0; i < 4; i++) begin
            pop();
            check_fifo($sformatf("overrun_pop%0d", i));
        end
        clear_errs();
        check_flags("overrun_clr");

        // False start: 4-tick low glitch.
        rx_serial = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch.busy_mid", 32'(rx_busy), 32'd1);
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        repeat (BIT) @(negedge clk);
        check("glitch.busy_end", 32'(rx_busy), 32'd0);
        check_fifo("glitch");

        // Abort mid-data of 0x77, then receive it cleanly.
        abort_byte = 8'h77;
        drive_bit(1'b0);
        drive_bit(abort_byte[0]);
        drive_bit(abort_byte[1]);
        rx_serial = abort_byte[2];
        repeat (BIT / 2) @(negedge clk);
        check("abort.busy_mid", 32'(rx_busy), 32'd1);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("abort.busy_off", 32'(rx_busy), 32'd0);
        repeat (BIT / 2) @(negedge clk);
        for (int i = 3; i < 8; i++) drive_bit(abort_byte[i]);
        drive_bit(1'b1);
        repeat (BIT) @(negedge clk);
        rx_en = 1'b1;
        check_fifo("abort");
        check_flags("abort");
        rx_frame(8'h77, 1'b0, 1'b1, 1'b1);
        check_fifo("abort_resend");
        pop();

        // Randomized frames against the model.
        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            parity_mode = 2'($urandom_range(0, 3));
            stop_bits   = 1'($urandom_range(0, 1));
            pb = (^d) ^ (parity_mode == 2'b10);
            if ($urandom_range(0, 2) == 0) pb = ~pb;
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            rx_frame(d, pb, s1, s2);
            check_fifo($sformatf("rand%0d", n));
            check_flags($sformatf("rand%0d", n));
            if ($urandom_range(0, 2) != 0) pop();
            if ($urandom_range(0, 5) == 0) clear_errs();
        end
        parity_mode = 2'b00;
        stop_bits   = 1'b0;

        // Reset mid-frame discards the FIFO and returns to idle.
        rx_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_brk = 1'b0;
        check("rst_mid.busy", 32'(rx_busy), 32'd0);
        check_fifo("rst_mid");
        check_flags("rst_mid");
        rx_serial = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver that succeeds the fixed 8N1 `uart_rx`. It adds:
- 5–9 data bits, runtime parity (none/even/odd) and 1 or 2 stop bits.
- Oversampled majority-vote bit sampling with false-start rejection.
- Break detection and a first-word-fall-through receive FIFO with per-word error tags.

It sits between the synchronised `rx_serial` pad and the APB register bank, which pops words through `rd_en`.

## Interface
- `CLK_FREQ`, 100_000_000, system clock in Hz
- `BAUD_RATE`, 9600, line rate in baud
- `DATA_BITS`, 8, data bits per frame, legal 5..9
- `OVERSAMPLE`, 16, sample ticks per bit, even, ≥8
- `FIFO_DEPTH`, 4, receive FIFO entries, power of 2, ≥2
- `clk` in 1, single system clock, all logic on rising edge
- `rst` in 1, synchronous active-high reset
- `rx_en` in 1, receiver enable
- `rx_serial` in 1, asynchronous serial line, idle high
- `parity_mode` in 2, 00 none, 01 even, 10 odd, 11 none
- `stop_bits` in 1, 0 = one stop bit, 1 = two stop bits
- `rd_en` in 1, pop FIFO head
- `err_clr` in 1, clear sticky `overrun` and `break_det`
- `rx_data` out DATA_BITS, FIFO head data
- `rx_perr` out 1, parity-error tag of head word
- `rx_ferr` out 1, framing-error tag of head word
- `rx_valid` out 1, FIFO non-empty
- `fifo_count` out $clog2(FIFO_DEPTH+1), entries held
- `rx_busy` out 1, FSM not in IDLE
- `overrun` out 1, sticky: word dropped because FIFO was full
- `break_det` out 1, sticky: break condition seen

## Operation
- **Reset.** All outputs are 0 except `rx_data` (0). FIFO is empty, FSM is IDLE, synchroniser flops are 1.
- **Input path.** `rx_serial` passes through a 2-FF synchroniser; a third flop provides falling-edge detect.
- **Tick generator.** DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated (651 at defaults). One tick every DIV clocks. The tick counter restarts on a start edge.
- **IDLE.** A synced falling edge with `rx_en`=1 enters START. Level-low alone never starts a frame.
- **Sampling.** Each bit is sampled at ticks M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the 2-of-3 majority.
- **START.** Majority 1 is a false start: return to IDLE, no flags, no push. Majority 0 goes to DATA. Each later bit is OVERSAMPLE ticks after the previous one.
- **DATA.** DATA_BITS bits, LSB first, into a shift register.
- **PARITY.** Entered only when `parity_mode` is 01 or 10. Even mode expects XOR(data, parity) = 0; odd mode expects 1. A mismatch sets the word's perr tag.
- **STOP.** 1 or 2 stop bits. Any stop sample of 0 sets the ferr tag and ends the frame at that sample.
- **Push.** The word is pushed at the last stop sample, or at the failing stop sample, then the FSM returns to IDLE.
- **Break.** If all data bits, the parity bit (if present) and the first stop bit are 0: no push, `break_det` is set, FSM enters BRK_WAIT. BRK_WAIT returns to IDLE once the synced line is 1.
- **FIFO.** Each entry is {ferr, perr, data}; head is combinational on `rx_data`/`rx_perr`/`rx_ferr`.
  - Push while full drops the word and sets `overrun`.
  - Push and `rd_en` in the same cycle while full: both succeed, no overrun.
  - `rd_en` while empty is ignored.
- **`rx_en` falling mid-frame.** FSM aborts to IDLE with no push and no flags. FIFO contents are kept.
- **`parity_mode` / `stop_bits` changes.** Sampled only at frame start and held for the whole frame.
- **`err_clr`.** Clears the sticky flags. If a set event occurs in the same cycle, set wins.
- **`rst` mid-frame.** Returns to the reset state next edge and discards the FIFO.

## Timing
- Synchroniser plus edge detect: 3 clk from pin to START entry.
- Push occurs ≈ (1+DATA_BITS+P+S−0.5)·OVERSAMPLE·DIV + 3 clk after the pin falls, where P = parity bits (0/1) and S = stop bits.
- `rx_valid` and `fifo_count` update the clk after the push.
- `rd_en` pop: the next head is visible the following clk.
- `rx_busy` is 1 from START entry through the last cycle in STOP or BRK_WAIT.
- Sticky flags rise the clk after the triggering sample.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** parity is handled as above.
- **Undefined:**
  - `parity_mode` is ignored and frames never contain a parity bit.
  - PARITY state logic is not built.
  - `rx_perr` is tied to 0.
  - Break detection checks data bits and first stop bit only.

## Test plan
- **Basic receive.** 8N1, send 0x55 then 0xA3, no reads → `fifo_count`=2, head 0x55, no tags. `rd_en` → head 0xA3.
- **Parity error.** Even parity, send 0xA3 with parity bit 1 (correct is 0) → head 0xA3, `rx_perr`=1, `rx_ferr`=0. Repeat with odd parity → `rx_perr`=0.
- **Framing error.** 2 stop bits, send 0x12 with second stop bit 0 → head 0x12, `rx_ferr`=1.
- **Break.** Hold line low for 20 bit times → `break_det`=1, `fifo_count`=0. Then idle and send 0x5A → pushed normally. `err_clr` → `break_det`=0.
- **Overrun and false start.**
  - FIFO_DEPTH=4, send 0x01..0x05 with no reads → count 4, heads 0x01..0x04, `overrun`=1.
  - Low glitch of 4 ticks → no push, `rx_busy` back to 0.
- **Abort.** Drop `rx_en` mid-data of 0x77 → no push, FSM idle. Re-enable and send 0x77 → received clean.
